reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the next CPU pipeline.
- Supports NUM_RD read ports and two write ports (A: ALU writeback, B: load writeback).
- Write-to-read bypass is optional; the zero register can be hardwired.
- A per-register busy scoreboard lets the hazard unit stall on pending writes. The block sits between the decode stage (reads, busy set) and the writeback stage (writes, busy clear).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching reads.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational; port k uses slice [k*DATA_W +: DATA_W].
- rd_busy_o  out  NUM_RD  busy bit of each read address after bypass resolution, combinational.
- wa_en_i  in  1  write port A enable.
- wa_addr_i  in  ADDR_W  write port A address.
- wa_data_i  in  DATA_W  write port A data.
- wb_en_i  in  1  write port B enable.
- wb_addr_i  in  ADDR_W  write port B address.
- wb_data_i  in  DATA_W  write port B data.
- busy_set_i  in  1  mark a register as pending (issue of a producer).
- busy_addr_i  in  ADDR_W  register to mark pending.
- busy_cnt_o  out  ADDR_W+1  number of registers currently busy, registered.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - All registers clear to 0, all busy bits clear, busy_cnt_o = 0.
  - Outputs are combinational from cleared state: rd_data_o = 0 (or bypass data if a write is enabled), rd_busy_o = 0.
  - Writes and busy sets presented during reset are ignored.
- Writes, sampled on the rising clock edge:
  - Each enabled port updates its addressed register.
  - Both ports enabled to the same address: port B wins.
  - With ZERO_REG=1, any write to address 0 is dropped.
- Busy scoreboard:
  - Any enabled write to address r clears busy[r] at the clock edge.
  - busy_set_i sets busy[busy_addr_i].
  - Set and clear on the same address in the same cycle: set wins, because the new producer supersedes the old one.
  - Setting an already-busy register keeps it busy; the count does not change.
  - With ZERO_REG=1, set on address 0 is ignored.
- busy_cnt_o equals popcount(busy) after the edge. It is maintained incrementally as +1 / -1 per changed bit, so it can change by -2..+1 per cycle, and it saturates naturally at depth.
- Read, per port k, combinational, priority from top to bottom:
  - ZERO_REG=1 and address 0: data 0, busy 0.
  - BYPASS=1, wb_en_i and wb_addr_i matches: wb_data_i, busy 0.
  - BYPASS=1, wa_en_i and wa_addr_i matches: wa_data_i, busy 0.
  - Otherwise: register contents and busy[addr].
- busy_set_i is never reflected in rd_busy_o in the same cycle; it is visible from the next cycle.
- With BYPASS=0, reads return the pre-edge value, and the write becomes visible the next cycle.
- Latency:
  - Read: 0 cycles.
  - Write visible to a non-bypassed read: 1 cycle.
  - Busy set visible: 1 cycle.
- Read ports are fully independent; multiple ports may read the same address.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant = 0.
  - localparam DEPTH = 2**ADDR_W, shared with the hazard unit.
- Sub-module rf_scoreboard holds the busy bit-vector, set/clear arbitration and busy_cnt_o.
- The read mux and bypass logic are instantiated per port via a generate loop in the top module.

Test Plan:
- Reset applied mid-run after writing r5=0x1234: all reads return 0, rd_busy_o=0, busy_cnt_o=0, asynchronously and before the next clock edge.
- Port A writes r3=0xAAAA and port B writes r3=0xBBBB in the same cycle, read r3 that cycle: BYPASS=1 gives 0xBBBB same cycle; BYPASS=0 gives old value, then 0xBBBB next cycle.
- Write 0xFFFF_FFFF to r0 with busy_set on r0: r0 reads 0, busy 0, busy_cnt_o unchanged (ZERO_REG=1). With ZERO_REG=0, r0 reads 0xFFFF_FFFF next cycle.
- Set busy on r7, next cycle read r7: rd_busy_o=1 and busy_cnt_o=1. Then port A writes r7 while busy_set targets r7 in the same cycle: busy remains 1 and the count stays 1.
- Set busy on r1, r2, r3 over consecutive cycles, then one cycle writes r1 (A) and r2 (B) together: busy_cnt_o goes 1, 2, 3, then 1.
- NUM_RD=4 with all ports reading r9 while port B writes 0x55: all four ports return 0x55 with busy 0 in the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: register-file geometry and read-source encoding.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int DEPTH      = 2**CPU_ADDR_W;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_WB,
    SRC_WA,
    SRC_RF
  } rd_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits with set/clear arbitration and a running count of busy registers.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_a_en,
  input  logic [ADDR_W-1:0]      clr_a_addr,
  input  logic                   clr_b_en,
  input  logic [ADDR_W-1:0]      clr_b_addr,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [N-1:0]    set_hit;
  logic [N-1:0]    clr_hit;
  logic [N-1:0]    busy_d;
  logic [N-1:0]    busy_q;
  logic [ADDR_W:0] cnt_d;
  logic [ADDR_W:0] cnt_q;

  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    if (set_en && !(ZERO_REG && set_addr == ADDR_W'(REG_ZERO)))
      set_hit[set_addr] = 1'b1;
    if (clr_a_en)
      clr_hit[clr_a_addr] = 1'b1;
    if (clr_b_en)
      clr_hit[clr_b_addr] = 1'b1;
  end

  // A new producer supersedes the retiring one, so set dominates clear.
  assign busy_d = set_hit | (busy_q & ~clr_hit);

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (busy_d[i] && !busy_q[i])
        cnt_d = cnt_d + CNT_ONE;
      else if (!busy_d[i] && busy_q[i])
        cnt_d = cnt_d - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two write ports, NUM_RD bypassed read ports, busy scoreboard.
module reg_file_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wa_en_i,
  input  logic [ADDR_W-1:0]        wa_addr_i,
  input  logic [DATA_W-1:0]        wa_data_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic                     busy_set_i,
  input  logic [ADDR_W-1:0]        busy_addr_i,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int RF_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]   regs_q [RF_DEPTH];
  logic [RF_DEPTH-1:0] busy;

  // Port B is the later (load) writeback and wins a same-address collision.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RF_DEPTH; i++)
        regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        if (!(ZERO_REG && i == REG_ZERO)) begin
          if (wb_en_i && wb_addr_i == ADDR_W'(i))
            regs_q[i] <= wb_data_i;
          else if (wa_en_i && wa_addr_i == ADDR_W'(i))
            regs_q[i] <= wa_data_i;
        end
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .set_en     (busy_set_i),
    .set_addr   (busy_addr_i),
    .clr_a_en   (wa_en_i),
    .clr_a_addr (wa_addr_i),
    .clr_b_en   (wb_en_i),
    .clr_b_addr (wb_addr_i),
    .busy       (busy),
    .busy_cnt   (busy_cnt_o)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    rd_src_e           src;
    logic [DATA_W-1:0] data;
    logic              busy_bit;

    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    always_comb begin
      if (ZERO_REG && addr == ADDR_W'(REG_ZERO))
        src = SRC_ZERO;
      else if (BYPASS && wb_en_i && wb_addr_i == addr)
        src = SRC_WB;
      else if (BYPASS && wa_en_i && wa_addr_i == addr)
        src = SRC_WA;
      else
        src = SRC_RF;
    end

    // Forwarded data is by definition no longer pending, so its busy reads 0.
    always_comb begin
      data     = regs_q[addr];
      busy_bit = busy[addr];
      case (src)
        SRC_ZERO: begin
          data     = '0;
          busy_bit = 1'b0;
        end
        SRC_WB: begin
          data     = wb_data_i;
          busy_bit = 1'b0;
        end
        SRC_WA: begin
          data     = wa_data_i;
          busy_bit = 1'b0;
        end
        default: ;
      endcase
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = data;
    assign rd_busy_o[k]                  = busy_bit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a bypassing 4-port zero-reg instance and a plain 2-port instance.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4*AW-1:0] rd_addr;
  logic [4*DW-1:0] rd_data_a;
  logic [3:0]      rd_busy_a;
  logic [AW:0]     cnt_a;
  logic [2*DW-1:0] rd_data_b;
  logic [1:0]      rd_busy_b;
  logic [AW:0]     cnt_b;
  logic            wa_en, wb_en, busy_set;
  logic [AW-1:0]   wa_addr, wb_addr, busy_addr;
  logic [DW-1:0]   wa_data, wb_data;

  int   cycle = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] act;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_set_i(busy_set), .busy_addr_i(busy_addr), .busy_cnt_o(cnt_a)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr[2*AW-1:0]), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_set_i(busy_set), .busy_addr_i(busy_addr), .busy_cnt_o(cnt_b)
  );

  function automatic logic [31:0] actual(input exp_t x);
    logic [31:0] r;
    r = '0;
    if (x.dut == 0) begin
      case (x.kind)
        0:       r = rd_data_a[x.port*DW +: DW];
        1:       r = {31'b0, rd_busy_a[x.port]};
        default: r = {26'b0, cnt_a};
      endcase
    end else begin
      case (x.kind)
        0:       r = rd_data_b[x.port*DW +: DW];
        1:       r = {31'b0, rd_busy_b[x.port]};
        default: r = {26'b0, cnt_b};
      endcase
    end
    return r;
  endfunction

  // Monitor: drain every expectation due this cycle, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      e = q.pop_front();
      act = actual(e);
      n_vec++;
      if (e.cyc != cycle || act !== e.val) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got %h, expected %h", e.name, e.dut, act, e.val);
      end
    end
  end

  task automatic push(input int dut, input int kind, input int port, input logic [31:0] val, input string name);
    exp_t x;
    x.cyc = cycle; x.dut = dut; x.kind = kind; x.port = port; x.val = val; x.name = name;
    q.push_back(x);
  endtask

  task automatic expect_rd(input int dut, input int port, input logic [31:0] d, input int b, input string tag);
    push(dut, 0, port, d, $sformatf("%s p%0d data", tag, port));
    push(dut, 1, port, b, $sformatf("%s p%0d busy", tag, port));
  endtask

  task automatic expect_cnt(input int c, input string tag);
    push(0, 2, 0, c, $sformatf("%s cnt", tag));
    push(1, 2, 0, c, $sformatf("%s cnt", tag));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    idle();
    rd_addr = '0;

    // Reset held: writes and busy sets must be ignored; bypass still forwards.
    step();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD; busy_set = 1'b1; busy_addr = 5'd5;
    set_rd(5, 5, 0, 0);
    expect_rd(0, 0, 32'hDEAD, 0, "rst byp");
    expect_rd(1, 0, 32'h0, 0, "rst nobyp");
    expect_cnt(0, "rst");

    step(); rst_n = 1'b1; idle(); set_rd(5, 5, 0, 0);
    expect_rd(0, 0, 32'h0, 0, "ign rst wr");
    expect_rd(1, 0, 32'h0, 0, "ign rst wr");
    expect_cnt(0, "ign rst set");

    step(); idle(); wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1234; busy_set = 1'b1; busy_addr = 5'd6;
    set_rd(5, 6, 0, 0);
    expect_rd(0, 0, 32'h1234, 0, "wr r5");
    expect_rd(1, 0, 32'h0, 0, "wr r5");

    step(); idle(); set_rd(5, 6, 0, 0);
    expect_rd(0, 0, 32'h1234, 0, "rd r5");
    expect_rd(1, 0, 32'h1234, 0, "rd r5");
    expect_rd(0, 1, 32'h0, 1, "rd r6");
    expect_rd(1, 1, 32'h0, 1, "rd r6");
    expect_cnt(1, "r6 busy");

    // Asynchronous reset mid-cycle, checked before the next edge.
    step(); idle(); set_rd(5, 6, 0, 0);
    #1 rst_n = 1'b0;
    expect_rd(0, 0, 32'h0, 0, "async rst r5");
    expect_rd(1, 0, 32'h0, 0, "async rst r5");
    expect_rd(0, 1, 32'h0, 0, "async rst r6");
    expect_rd(1, 1, 32'h0, 0, "async rst r6");
    expect_cnt(0, "async rst");

    step(); rst_n = 1'b1; idle(); wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h1111;

    // Same-address collision: B wins, both for bypass and for the stored value.
    step(); idle();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hAAAA;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hBBBB;
    set_rd(3, 4, 0, 0);
    expect_rd(0, 0, 32'hBBBB, 0, "coll same");
    expect_rd(1, 0, 32'h1111, 0, "coll same");
    expect_rd(0, 1, 32'h0, 0, "coll other");
    expect_rd(1, 1, 32'h0, 0, "coll other");

    step(); idle(); set_rd(3, 4, 0, 0);
    expect_rd(0, 0, 32'hBBBB, 0, "coll next");
    expect_rd(1, 0, 32'hBBBB, 0, "coll next");

    // Zero register: write and busy set on r0.
    step(); idle();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF; busy_set = 1'b1; busy_addr = 5'd0;
    set_rd(0, 0, 0, 0);
    expect_rd(0, 0, 32'h0, 0, "r0 wr");
    expect_rd(1, 0, 32'h0, 0, "r0 wr");
    expect_cnt(0, "r0 wr");

    step(); idle(); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0;
    set_rd(0, 0, 0, 0);
    expect_rd(0, 0, 32'h0, 0, "r0 next");
    expect_rd(1, 0, 32'hFFFF_FFFF, 1, "r0 next");
    push(0, 2, 0, 0, "r0 next cnt");
    push(1, 2, 0, 1, "r0 next cnt");

    // Busy on r7, then write and set together: set wins.
    step(); idle(); busy_set = 1'b1; busy_addr = 5'd7; set_rd(7, 0, 0, 0);
    expect_rd(0, 0, 32'h0, 0, "set r7 same");
    expect_rd(1, 0, 32'h0, 0, "set r7 same");
    expect_cnt(0, "set r7 same");

    step(); idle(); set_rd(7, 0, 0, 0);
    expect_rd(0, 0, 32'h0, 1, "r7 busy");
    expect_rd(1, 0, 32'h0, 1, "r7 busy");
    expect_cnt(1, "r7 busy");

    step(); idle();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h77; busy_set = 1'b1; busy_addr = 5'd7;
    set_rd(7, 0, 0, 0);
    expect_rd(0, 0, 32'h77, 0, "r7 wr+set");
    expect_rd(1, 0, 32'h0, 1, "r7 wr+set");
    expect_cnt(1, "r7 wr+set");

    step(); idle();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h70; busy_set = 1'b1; busy_addr = 5'd1;
    set_rd(7, 0, 0, 0);
    expect_rd(0, 0, 32'h70, 0, "r7 still busy");
    expect_rd(1, 0, 32'h77, 1, "r7 still busy");
    expect_cnt(1, "r7 still busy");

    // Counting sequence r1, r2, r3 then a double clear.
    step(); idle(); busy_set = 1'b1; busy_addr = 5'd2; set_rd(7, 0, 0, 0);
    expect_rd(0, 0, 32'h70, 0, "r7 cleared");
    expect_rd(1, 0, 32'h70, 0, "r7 cleared");
    expect_cnt(1, "cnt1");

    step(); idle(); busy_set = 1'b1; busy_addr = 5'd3;
    expect_cnt(2, "cnt2");

    step(); idle();
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    set_rd(1, 2, 3, 0);
    expect_cnt(3, "cnt3");
    expect_rd(0, 0, 32'h11, 0, "dbl clr");
    expect_rd(0, 1, 32'h22, 0, "dbl clr");
    expect_rd(0, 2, 32'hBBBB, 1, "dbl clr");
    expect_rd(1, 0, 32'h0, 1, "dbl clr");
    expect_rd(1, 1, 32'h0, 1, "dbl clr");

    step(); idle(); set_rd(1, 2, 3, 0);
    expect_cnt(1, "cnt after dbl");
    expect_rd(0, 0, 32'h11, 0, "after dbl");
    expect_rd(0, 1, 32'h22, 0, "after dbl");
    expect_rd(0, 2, 32'hBBBB, 1, "after dbl");
    expect_rd(1, 0, 32'h11, 0, "after dbl");
    expect_rd(1, 1, 32'h22, 0, "after dbl");

    // All ports on r9 while port B writes it.
    step(); idle(); wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    set_rd(9, 9, 9, 9);
    for (int p = 0; p < 4; p++) expect_rd(0, p, 32'h55, 0, "r9 byp");
    for (int p = 0; p < 2; p++) expect_rd(1, p, 32'h0, 0, "r9 nobyp");

    step(); idle(); set_rd(9, 9, 9, 9);
    for (int p = 0; p < 4; p++) expect_rd(0, p, 32'h55, 0, "r9 next");
    for (int p = 0; p < 2; p++) expect_rd(1, p, 32'h55, 0, "r9 next");

    step();
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending, expected 0", q.size());
      n_bad += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
